// File: rtl/gpio_ctrl_pkg.sv
// rtl/gpio_ctrl_pkg.sv - register offsets, register index enum and bus helpers for gpio_ctrl
//
// Shared by gpio_ctrl and its bench. Holds the 12-bit register offsets, the
// register-index enum produced by the address decoder, and two small helpers:
// offset decode and byte-enable to bit-mask expansion.

package gpio_ctrl_pkg;

    localparam logic [11:0] OFF_OUT        = 12'h000;
    localparam logic [11:0] OFF_IN         = 12'h004;
    localparam logic [11:0] OFF_IN_DBNC    = 12'h008;
    localparam logic [11:0] OFF_OUT_SET    = 12'h00C;
    localparam logic [11:0] OFF_OUT_CLR    = 12'h010;
    localparam logic [11:0] OFF_RISE_EN    = 12'h014;
    localparam logic [11:0] OFF_FALL_EN    = 12'h018;
    localparam logic [11:0] OFF_INTR_STATE = 12'h01C;

    typedef enum logic [3:0] {
        REG_OUT,
        REG_IN,
        REG_IN_DBNC,
        REG_OUT_SET,
        REG_OUT_CLR,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_INTR_STATE,
        REG_NONE
    } reg_idx_e;

    // Exact match on the full 12-bit offset; misaligned or unlisted offsets
    // fall through to REG_NONE so they read 0 and ignore writes.
    function automatic reg_idx_e decode_offset(input logic [11:0] off);
        reg_idx_e idx;
        case (off)
            OFF_OUT:        idx = REG_OUT;
            OFF_IN:         idx = REG_IN;
            OFF_IN_DBNC:    idx = REG_IN_DBNC;
            OFF_OUT_SET:    idx = REG_OUT_SET;
            OFF_OUT_CLR:    idx = REG_OUT_CLR;
            OFF_RISE_EN:    idx = REG_RISE_EN;
            OFF_FALL_EN:    idx = REG_FALL_EN;
            OFF_INTR_STATE: idx = REG_INTR_STATE;
            default:        idx = REG_NONE;
        endcase
        return idx;
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_dbnc.sv
// rtl/gpio_dbnc.sv - single-bit debouncer with a consecutive-cycle stability window
//
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   d_i     already-synchronised input bit
//   q_o     debounced bit
//
// q_o follows d_i only after d_i has differed from q_o for DbncCycles
// consecutive cycles; any cycle where they agree restarts the count.
// DbncCycles = 0 turns the block into a wire.

module gpio_dbnc #(
    parameter int DbncCycles = 500
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DbncCycles == 0) begin : g_bypass
            logic unused_clk;
            assign unused_clk = clk_i ^ rst_ni;
            assign q_o        = d_i;
        end else begin : g_count
            localparam int CntW = $clog2(DbncCycles + 1);
            localparam logic [CntW-1:0] CntLast = CntW'(DbncCycles - 1);

            logic [CntW-1:0] cnt_q;
            logic            q_q;

            // The update happens on the edge that samples the DbncCycles-th
            // differing cycle, so the counter only needs to reach DbncCycles-1.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                    q_q   <= 1'b0;
                end else if (d_i != q_q) begin
                    if (cnt_q == CntLast) begin
                        q_q   <= d_i;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign q_o = q_q;
        end
    endgenerate

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO controller: registered outputs, synchronised and debounced inputs, edge interrupts
//
// Ports:
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   device_req_i        single-cycle bus request
//   device_addr_i       byte address, bits [11:0] decoded
//   device_we_i         1 = write, 0 = read
//   device_be_i         write byte enables
//   device_wdata_i      write data
//   device_rvalid_o     response, exactly one cycle after every request
//   device_rdata_o      read data (0 for writes, WO and unmapped offsets)
//   gp_i                asynchronous external inputs
//   gp_o                registered outputs (the OUT register)
//   irq_o               OR of INTR_STATE, driven from flops only

module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int GpiWidth   = 8,
    parameter int GpoWidth   = 16,
    parameter int DbncCycles = 500
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    input  logic [GpiWidth-1:0] gp_i,
    output logic [GpoWidth-1:0] gp_o,
    output logic                irq_o
);

    logic [GpoWidth-1:0] out_q, out_d;
    logic [GpiWidth-1:0] sync1_q, sync2_q;
    logic [GpiWidth-1:0] dbnc, dbnc_prev_q;
    logic [GpiWidth-1:0] rise_en_q, rise_en_d;
    logic [GpiWidth-1:0] fall_en_q, fall_en_d;
    logic [GpiWidth-1:0] intr_q, intr_d, intr_clr, edge_set;
    logic                rvalid_q;
    logic [31:0]         rdata_q, rdata_d;

    reg_idx_e    idx;
    logic        wr;
    logic [31:0] wmask, wbits;

    assign idx   = decode_offset(device_addr_i[11:0]);
    assign wr    = device_req_i & device_we_i;
    assign wmask = be_to_mask(device_be_i);
    assign wbits = device_wdata_i & wmask;

    // Upper address bits and write-data bits above the register widths are
    // deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{device_addr_i[31:12], wmask, wbits};

    // Two-flop synchroniser on the asynchronous inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gp_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < GpiWidth; i++) begin : g_dbnc
        gpio_dbnc #(
            .DbncCycles(DbncCycles)
        ) u_dbnc (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (sync2_q[i]),
            .q_o   (dbnc[i])
        );
    end

    // Edges are taken on the debounced value against its own previous cycle.
    assign edge_set = (dbnc & ~dbnc_prev_q & rise_en_q)
                    | (~dbnc & dbnc_prev_q & fall_en_q);

    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        intr_clr  = '0;
        if (wr) begin
            case (idx)
                REG_OUT:        out_d = (out_q & ~wmask[GpoWidth-1:0]) | wbits[GpoWidth-1:0];
                REG_OUT_SET:    out_d = out_q | wbits[GpoWidth-1:0];
                REG_OUT_CLR:    out_d = out_q & ~wbits[GpoWidth-1:0];
                REG_RISE_EN:    rise_en_d = (rise_en_q & ~wmask[GpiWidth-1:0]) | wbits[GpiWidth-1:0];
                REG_FALL_EN:    fall_en_d = (fall_en_q & ~wmask[GpiWidth-1:0]) | wbits[GpiWidth-1:0];
                REG_INTR_STATE: intr_clr = wbits[GpiWidth-1:0];
                default: ;
            endcase
        end
        // The set term is ORed in after the clear so a coincident edge wins.
        intr_d = (intr_q & ~intr_clr) | edge_set;
    end

    always_comb begin
        rdata_d = '0;
        if (device_req_i && !device_we_i) begin
            case (idx)
                REG_OUT:        rdata_d[GpoWidth-1:0] = out_q;
                REG_IN:         rdata_d[GpiWidth-1:0] = sync2_q;
                REG_IN_DBNC:    rdata_d[GpiWidth-1:0] = dbnc;
                REG_RISE_EN:    rdata_d[GpiWidth-1:0] = rise_en_q;
                REG_FALL_EN:    rdata_d[GpiWidth-1:0] = fall_en_q;
                REG_INTR_STATE: rdata_d[GpiWidth-1:0] = intr_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            intr_q      <= '0;
            dbnc_prev_q <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            out_q       <= out_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            intr_q      <= intr_d;
            dbnc_prev_q <= dbnc;
            rvalid_q    <= device_req_i;
            rdata_q     <= rdata_d;
        end
    end

    assign gp_o            = out_q;
    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign irq_o           = |intr_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl

module tb_gpio_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        device_req_i = 1'b0;
    logic [31:0] device_addr_i = '0;
    logic        device_we_i = 1'b0;
    logic [3:0]  device_be_i = '0;
    logic [31:0] device_wdata_i = '0;
    logic        device_rvalid_o;
    logic [31:0] device_rdata_o;
    logic [7:0]  gp_i = '0;
    logic [15:0] gp_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    gpio_ctrl #(
        .GpiWidth  (8),
        .GpoWidth  (16),
        .DbncCycles(4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .device_req_i   (device_req_i),
        .device_addr_i  (device_addr_i),
        .device_we_i    (device_we_i),
        .device_be_i    (device_be_i),
        .device_wdata_i (device_wdata_i),
        .device_rvalid_o(device_rvalid_o),
        .device_rdata_o (device_rdata_o),
        .gp_i           (gp_i),
        .gp_o           (gp_o),
        .irq_o          (irq_o)
    );

    // Called at a negedge; returns at the following negedge with the response.
    task automatic bus_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic [3:0] be, output logic rv, output logic [31:0] rd);
        device_req_i   = 1'b1;
        device_addr_i  = addr;
        device_we_i    = we;
        device_wdata_i = wdata;
        device_be_i    = be;
        @(posedge clk_i);
        @(negedge clk_i);
        device_req_i = 1'b0;
        device_we_i  = 1'b0;
        rv = device_rvalid_o;
        rd = device_rdata_o;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset();
        logic rv;
        logic [31:0] rd;
        checks++; if (gp_o !== 16'h0) begin errors++; $display("FAIL reset_gp_o: got %h expected 0000", gp_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        checks++; if (device_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", device_rvalid_o); end
        checks++; if (device_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", device_rdata_o); end
        rst_ni = 1'b1;
        wait_cyc(2);
        bus_xfer(32'h1C, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL reset_intr_read: got rv=%b rd=%h expected rv=1 rd=0", rv, rd); end
    endtask

    task automatic test_out_be();
        logic rv;
        logic [31:0] rd;
        bus_xfer(32'h00, 1'b1, 32'h0000_1234, 4'hF, rv, rd);
        bus_xfer(32'h00, 1'b1, 32'h0000_A5A5, 4'b0001, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL be_write_resp: got rv=%b rd=%h expected rv=1 rd=0", rv, rd); end
        checks++; if (gp_o !== 16'h12A5) begin errors++; $display("FAIL be_gp_o: got %h expected 12a5", gp_o); end
        bus_xfer(32'h00, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0000_12A5) begin errors++; $display("FAIL be_read_out: got %h expected 000012a5", rd); end
        bus_xfer(32'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, rv, rd);
        bus_xfer(32'h00, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0000_FFFF || gp_o !== 16'hFFFF) begin errors++; $display("FAIL out_width: got rd=%h gp_o=%h expected 0000ffff ffff", rd, gp_o); end
        bus_xfer(32'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, rv, rd);
        bus_xfer(32'h40, 1'b1, 32'hFFFF_FFFF, 4'hF, rv, rd);
        bus_xfer(32'h40, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0 || gp_o !== 16'hFFFF) begin errors++; $display("FAIL unmapped: got rv=%b rd=%h gp_o=%h expected 1 0 ffff", rv, rd, gp_o); end
        bus_xfer(32'h0000_1000, 1'b1, 32'h0, 4'hF, rv, rd);
        checks++; if (gp_o !== 16'h0000) begin errors++; $display("FAIL addr_alias: got %h expected 0000", gp_o); end
    endtask

    task automatic test_set_clr();
        logic rv;
        logic [31:0] rd;
        bus_xfer(32'h00, 1'b1, 32'h0000_00F0, 4'hF, rv, rd);
        bus_xfer(32'h0C, 1'b1, 32'h0000_000F, 4'hF, rv, rd);
        checks++; if (gp_o !== 16'h00FF) begin errors++; $display("FAIL out_set: got %h expected 00ff", gp_o); end
        bus_xfer(32'h10, 1'b1, 32'h0000_0030, 4'hF, rv, rd);
        checks++; if (gp_o !== 16'h00CF) begin errors++; $display("FAIL out_clr: got %h expected 00cf", gp_o); end
        bus_xfer(32'h0C, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL wo_read: got rv=%b rd=%h expected 1 0", rv, rd); end
    endtask

    task automatic test_back_to_back();
        device_req_i   = 1'b1;
        device_we_i    = 1'b1;
        device_addr_i  = 32'h00;
        device_wdata_i = 32'h0000_1111;
        device_be_i    = 4'hF;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (device_rvalid_o !== 1'b1 || device_rdata_o !== 32'h0) begin errors++; $display("FAIL b2b_wr_resp: got rv=%b rd=%h expected 1 0", device_rvalid_o, device_rdata_o); end
        device_we_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        device_req_i = 1'b0;
        checks++; if (device_rvalid_o !== 1'b1 || device_rdata_o !== 32'h0000_1111) begin errors++; $display("FAIL b2b_rd_resp: got rv=%b rd=%h expected 1 00001111", device_rvalid_o, device_rdata_o); end
        @(negedge clk_i);
        checks++; if (device_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_drop: got %b expected 0", device_rvalid_o); end
    endtask

    task automatic test_sync();
        logic rv;
        logic [31:0] rd;
        gp_i = 8'h5A;
        bus_xfer(32'h04, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sync_edge1: got %h expected 0", rd); end
        bus_xfer(32'h04, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sync_edge2: got %h expected 0", rd); end
        bus_xfer(32'h04, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL sync_edge3: got %h expected 5a", rd); end
        gp_i = 8'h00;
        wait_cyc(12);
    endtask

    task automatic test_debounce();
        logic rv;
        logic [31:0] rd;
        gp_i = 8'h01;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        gp_i = 8'h00;
        wait_cyc(10);
        bus_xfer(32'h08, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dbnc_glitch: got %h expected 0", rd); end
        gp_i = 8'h01;
        wait_cyc(5);
        bus_xfer(32'h08, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dbnc_early: got %h expected 0", rd); end
        bus_xfer(32'h08, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL dbnc_on_time: got %h expected 1", rd); end
        gp_i = 8'h00;
        wait_cyc(12);
    endtask

    task automatic test_rise_irq();
        logic rv;
        logic [31:0] rd;
        bus_xfer(32'h14, 1'b1, 32'h01, 4'hF, rv, rd);
        gp_i = 8'h01;
        wait_cyc(12);
        bus_xfer(32'h1C, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h1 || irq_o !== 1'b1) begin errors++; $display("FAIL rise_intr: got rd=%h irq=%b expected 1 1", rd, irq_o); end
        bus_xfer(32'h14, 1'b1, 32'h00, 4'hF, rv, rd);
        bus_xfer(32'h1C, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL en_clear_keeps: got %h expected 1", rd); end
        bus_xfer(32'h1C, 1'b1, 32'h01, 4'hF, rv, rd);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq_o); end
        gp_i = 8'h00;
        wait_cyc(12);
    endtask

    task automatic test_fall_coincide();
        logic rv;
        logic [31:0] rd;
        bus_xfer(32'h18, 1'b1, 32'h80, 4'hF, rv, rd);
        gp_i = 8'h80;
        wait_cyc(12);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL fall_no_rise_irq: got %b expected 0", irq_o); end
        gp_i = 8'h00;
        wait_cyc(6);
        bus_xfer(32'h1C, 1'b1, 32'h80, 4'hF, rv, rd);
        bus_xfer(32'h1C, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h80 || irq_o !== 1'b1) begin errors++; $display("FAIL set_wins: got rd=%h irq=%b expected 80 1", rd, irq_o); end
        bus_xfer(32'h1C, 1'b1, 32'h80, 4'hF, rv, rd);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL fall_w1c: got %b expected 0", irq_o); end
        bus_xfer(32'h18, 1'b1, 32'h00, 4'hF, rv, rd);
    endtask

    task automatic test_reset_mid();
        logic rv;
        logic [31:0] rd;
        bus_xfer(32'h14, 1'b1, 32'h02, 4'hF, rv, rd);
        gp_i = 8'h02;
        wait_cyc(12);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq_o); end
        gp_i = 8'h03;
        wait_cyc(3);
        device_req_i  = 1'b1;
        device_we_i   = 1'b0;
        device_addr_i = 32'h00;
        @(posedge clk_i);
        #2;
        device_req_i = 1'b0;
        rst_ni = 1'b0;
        gp_i = 8'h00;
        #1;
        checks++; if (gp_o !== 16'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got gp_o=%h irq=%b expected 0 0", gp_o, irq_o); end
        checks++; if (device_rvalid_o !== 1'b0 || device_rdata_o !== 32'h0) begin errors++; $display("FAIL mid_reset_bus: got rv=%b rd=%h expected 0 0", device_rvalid_o, device_rdata_o); end
        wait_cyc(3);
        rst_ni = 1'b1;
        wait_cyc(20);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b expected 0", irq_o); end
        bus_xfer(32'h1C, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_intr: got %h expected 0", rd); end
        bus_xfer(32'h08, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_dbnc: got %h expected 0", rd); end
        bus_xfer(32'h14, 1'b0, '0, 4'h0, rv, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_rise_en: got %h expected 0", rd); end
    endtask

    initial begin
        wait_cyc(3);
        test_reset();
        test_out_be();
        test_set_clr();
        test_back_to_back();
        test_sync();
        test_debounce();
        test_rise_irq();
        test_fall_coincide();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
